cache_set_assoc: RTL and testbench
==================================

// Module: cache_set_assoc
// PURPOSE
//  Read-only N-way set-associative instruction cache between fetch and the line-wide memory port.
//  Successor of the direct-mapped cache: parametrised ways/sets/line size, valid bits, round-robin
//  victim with invalid-way priority, single-cycle flush, hit/miss counters, back-to-back hits.
// PARAMETERS
//  ByteOffsetBits  4   log2(bytes per line); NrWordsPerLine = 2**ByteOffsetBits/4 (>=1)
//  IndexBits       6   log2(sets); NrSets = 2**IndexBits
//  NrWays          2   ways per set, power of 2, >=1 (1 = direct-mapped)
//  CntBits         32  width of hit/miss counters
//  derived: TagBits = 32-IndexBits-ByteOffsetBits; LineSize = 32*NrWordsPerLine
// PORTS
//  clk_i            in   1         clock, rising edge
//  rstn_i           in   1         async reset, active low
//  addr_i           in   32        fetch byte address, word aligned
//  read_en_i        in   1         request; held with addr_i stable until read_valid_o
//  read_valid_o     out  1         read_word_o valid this cycle
//  read_word_o      out  32        addressed word
//  flush_i          in   1         invalidate all lines
//  mem_addr_o       out  32        line-aligned refill address {tag,index,0}
//  mem_read_en_o    out  1         refill request
//  mem_read_valid_i in   1         refill data valid (one-cycle pulse)
//  mem_read_data_i  in   LineSize  line; word 0 in bits [31:0], word k in [32k+31:32k]
//  hit_cnt_o        out  CntBits   hits returned since reset/flush
//  miss_cnt_o       out  CntBits   refills started since reset/flush
// BEHAVIOUR
//  Reset (async): state IDLE; all valid=0; victim pointers=0; counters=0; all outputs 0.
//  Hit = read_en_i & exists way w: valid[set][w] & tag[set][w]==tag(addr_i); >1 matching way impossible.
//  Word select: word index = addr_i[ByteOffsetBits-1:2], mux (no barrel shifter).
//  FSM (registered state, outputs combinational):
//   IDLE:    outputs 0. read_en_i & hit -> RESPOND; read_en_i & miss -> REFILL (miss_cnt++).
//   REFILL:  mem_read_en_o=1, mem_addr_o=line addr. On mem_read_valid_i: write line+tag into victim way,
//            set valid, advance set's victim pointer (mod NrWays), -> RESPOND.
//   RESPOND: read_valid_o=hit, read_word_o=hit way word, else 0. Each cycle with hit: hit_cnt++.
//            New addr_i hit -> stay (1 word/cycle); miss -> REFILL same edge (miss_cnt++).
//  Victim: lowest-index invalid way if any, else set's round-robin pointer; pointer only moves on refill.
//  Latency: hit from IDLE = 1 cycle after read_en_i rises; back-to-back hits in RESPOND = 0 cycles;
//   miss = memory latency + 1 cycle after mem_read_valid_i.
//  read_en_i=0 in any state -> IDLE next edge; refill in progress abandoned, no line written.
//  flush_i (highest priority over read_en_i): next edge all valid=0, pointers=0, counters=0, state IDLE;
//   aborts refill; mem_read_valid_i coinciding with flush is discarded.
//  mem_read_valid_i outside REFILL ignored. addr_i changes during REFILL are illegal (line tagged with live addr).
//  Counters saturate at all-ones (no wrap).
// TESTING
//  Cold miss 0x0000_0104: mem_read_en_o=1, mem_addr_o=0x0000_0100; reply line {D3,D2,D1,D0} -> next cycle read_word_o=D1, valid=1, miss_cnt=1.
//  Then 0x100,0x108,0x10C consecutive cycles -> D0,D2,D3 one per cycle, no mem_read_en_o, hit_cnt=4.
//  NrWays=2: miss 0x0000_0100, 0x0000_0500, 0x0000_0900 (same set) -> third evicts way0 (0x100); 0x500 hits, 0x100 misses.
//  flush_i during REFILL: next cycle mem_read_en_o=0, state IDLE, counters 0; late mem_read_valid_i writes nothing; re-read 0x100 misses.
//  read_en_i dropped mid-REFILL then reasserted: refill restarts, read_valid_o only after new mem_read_valid_i.
//  rstn_i low mid-RESPOND: outputs 0 immediately (async); after release first access to any address misses.

Source files
------------

// File: rtl/cache_set_assoc.sv
// cache_set_assoc
//   Read-only N-way set-associative instruction cache sitting between the
//   fetch stage and a line-wide memory port. Valid bits per way, round-robin
//   victim per set with priority for invalid ways, single-cycle flush,
//   saturating hit/miss counters, one word per cycle on back-to-back hits.
//
// Ports
//   clk_i            clock, rising edge
//   rstn_i           asynchronous reset, active low
//   addr_i           fetch byte address (word aligned), held with read_en_i
//   read_en_i        fetch request
//   read_valid_o     read_word_o valid this cycle
//   read_word_o      addressed word
//   flush_i          invalidate every line, clear pointers and counters
//   mem_addr_o       line-aligned refill address
//   mem_read_en_o    refill request
//   mem_read_valid_i refill data valid (one-cycle pulse)
//   mem_read_data_i  refill line, word k in bits [32k+31:32k]
//   hit_cnt_o        hits returned since reset/flush
//   miss_cnt_o       refills started since reset/flush
module cache_set_assoc #(
    parameter int ByteOffsetBits = 4,
    parameter int IndexBits      = 6,
    parameter int NrWays         = 2,
    parameter int CntBits        = 32,
    localparam int NrWordsPerLine = (2 ** ByteOffsetBits) / 4,
    localparam int LineSize       = 32 * NrWordsPerLine
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [31:0]         addr_i,
    input  logic                read_en_i,
    output logic                read_valid_o,
    output logic [31:0]         read_word_o,
    input  logic                flush_i,
    output logic [31:0]         mem_addr_o,
    output logic                mem_read_en_o,
    input  logic                mem_read_valid_i,
    input  logic [LineSize-1:0] mem_read_data_i,
    output logic [CntBits-1:0]  hit_cnt_o,
    output logic [CntBits-1:0]  miss_cnt_o
);
    localparam int NrSets   = 2 ** IndexBits;
    localparam int TagBits  = 32 - IndexBits - ByteOffsetBits;
    localparam int WayBits  = (NrWays > 1) ? $clog2(NrWays) : 1;
    localparam int WordBits = (NrWordsPerLine > 1) ? $clog2(NrWordsPerLine) : 1;

    typedef enum logic [1:0] {IDLE, REFILL, RESPOND} state_t;

    state_t state_reg, state_next;

    // Storage arrays are never reset: the valid bits alone qualify contents.
    logic [TagBits-1:0]  tag_mem  [NrWays][NrSets];
    logic [LineSize-1:0] data_mem [NrWays][NrSets];
    logic [NrWays-1:0]   valid_reg      [NrSets];
    logic [WayBits-1:0]  victim_ptr_reg [NrSets];
    logic [CntBits-1:0]  hit_cnt_reg, miss_cnt_reg;

    logic [TagBits-1:0]   tag;
    logic [IndexBits-1:0] set_idx;
    logic [WordBits-1:0]  word_idx;
    logic [NrWays-1:0]    way_match;
    logic                 hit;
    logic [LineSize-1:0]  hit_line;
    logic [31:0]          line_words [NrWordsPerLine];
    logic [31:0]          hit_word;
    logic [WayBits-1:0]   victim_way;
    logic                 found_invalid;
    logic                 refill_done;
    logic                 start_miss;
    logic                 count_hit;
    logic                 unused_addr_bits;

    assign tag              = addr_i[31 -: TagBits];
    assign set_idx          = addr_i[ByteOffsetBits +: IndexBits];
    assign unused_addr_bits = ^addr_i[1:0];

    genvar gi;
    generate
        if (NrWordsPerLine > 1) begin : g_word_idx
            assign word_idx = addr_i[2 +: WordBits];
        end else begin : g_word_idx_single
            assign word_idx = '0;
        end

        for (gi = 0; gi < NrWays; gi++) begin : g_match
            assign way_match[gi] = valid_reg[set_idx][gi] && (tag_mem[gi][set_idx] == tag);
        end

        for (gi = 0; gi < NrWordsPerLine; gi++) begin : g_words
            assign line_words[gi] = hit_line[32*gi +: 32];
        end
    endgenerate

    assign hit      = read_en_i && (|way_match);
    assign hit_word = line_words[word_idx];

    // At most one way matches, so an AND-OR select is a clean one-hot mux.
    always_comb begin
        hit_line = '0;
        for (int w = 0; w < NrWays; w++) begin
            hit_line = hit_line | (data_mem[w][set_idx] & {LineSize{way_match[w]}});
        end
    end

    // Lowest-index invalid way wins; otherwise the set's round-robin pointer.
    always_comb begin
        victim_way    = victim_ptr_reg[set_idx];
        found_invalid = 1'b0;
        for (int w = 0; w < NrWays; w++) begin
            if (!found_invalid && !valid_reg[set_idx][w]) begin
                victim_way    = WayBits'(w);
                found_invalid = 1'b1;
            end
        end
    end

    assign refill_done = (state_reg == REFILL) && read_en_i && mem_read_valid_i && !flush_i;

    always_comb begin
        state_next    = state_reg;
        read_valid_o  = 1'b0;
        read_word_o   = '0;
        mem_read_en_o = 1'b0;
        mem_addr_o    = '0;
        start_miss    = 1'b0;
        count_hit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (read_en_i) begin
                    if (hit) begin
                        state_next = RESPOND;
                    end else begin
                        state_next = REFILL;
                        start_miss = 1'b1;
                    end
                end
            end
            REFILL: begin
                mem_read_en_o = 1'b1;
                mem_addr_o    = {addr_i[31:ByteOffsetBits], {ByteOffsetBits{1'b0}}};
                if (!read_en_i) begin
                    state_next = IDLE;
                end else if (mem_read_valid_i) begin
                    state_next = RESPOND;
                end
            end
            RESPOND: begin
                read_valid_o = hit;
                read_word_o  = hit ? hit_word : '0;
                if (!read_en_i) begin
                    state_next = IDLE;
                end else if (hit) begin
                    count_hit = 1'b1;
                end else begin
                    state_next = REFILL;
                    start_miss = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        // Flush overrides any request in flight.
        if (flush_i) begin
            state_next = IDLE;
            start_miss = 1'b0;
            count_hit  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_reg    <= IDLE;
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
            for (int s = 0; s < NrSets; s++) begin
                valid_reg[s]      <= '0;
                victim_ptr_reg[s] <= '0;
            end
        end else begin
            state_reg <= state_next;
            if (flush_i) begin
                hit_cnt_reg  <= '0;
                miss_cnt_reg <= '0;
                for (int s = 0; s < NrSets; s++) begin
                    valid_reg[s]      <= '0;
                    victim_ptr_reg[s] <= '0;
                end
            end else begin
                if (refill_done) begin
                    valid_reg[set_idx][victim_way] <= 1'b1;
                    victim_ptr_reg[set_idx] <= (victim_ptr_reg[set_idx] == WayBits'(NrWays - 1)) ?
                                               '0 : victim_ptr_reg[set_idx] + 1'b1;
                end
                if (start_miss && (miss_cnt_reg != {CntBits{1'b1}})) begin
                    miss_cnt_reg <= miss_cnt_reg + 1'b1;
                end
                if (count_hit && (hit_cnt_reg != {CntBits{1'b1}})) begin
                    hit_cnt_reg <= hit_cnt_reg + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (refill_done) begin
            tag_mem[victim_way][set_idx]  <= tag;
            data_mem[victim_way][set_idx] <= mem_read_data_i;
        end
    end

    assign hit_cnt_o  = hit_cnt_reg;
    assign miss_cnt_o = miss_cnt_reg;

endmodule

// File: tb/tb_cache_set_assoc.sv
// tb_cache_set_assoc
//   Scoreboard bench for cache_set_assoc (4-word lines, 64 sets, 2 ways).
//   Expected words are queued when a fetch is driven and popped when the
//   cache raises read_valid_o; the bench also plays the memory side.
module tb_cache_set_assoc;
    logic         clk_i = 1'b0;
    logic         rstn_i;
    logic [31:0]  addr_i;
    logic         read_en_i;
    logic         read_valid_o;
    logic [31:0]  read_word_o;
    logic         flush_i;
    logic [31:0]  mem_addr_o;
    logic         mem_read_en_o;
    logic         mem_read_valid_i;
    logic [127:0] mem_read_data_i;
    logic [31:0]  hit_cnt_o;
    logic [31:0]  miss_cnt_o;

    cache_set_assoc #(
        .ByteOffsetBits(4),
        .IndexBits(6),
        .NrWays(2),
        .CntBits(32)
    ) dut (
        .clk_i(clk_i),
        .rstn_i(rstn_i),
        .addr_i(addr_i),
        .read_en_i(read_en_i),
        .read_valid_o(read_valid_o),
        .read_word_o(read_word_o),
        .flush_i(flush_i),
        .mem_addr_o(mem_addr_o),
        .mem_read_en_o(mem_read_en_o),
        .mem_read_valid_i(mem_read_valid_i),
        .mem_read_data_i(mem_read_data_i),
        .hit_cnt_o(hit_cnt_o),
        .miss_cnt_o(miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_q [$];
    int          exp_hits = 0;
    int          exp_misses = 0;
    int          salt = 0;
    int          mem_lat = 1;

    // Memory contents: word k of a line is a hash of line address, k and a
    // salt that changes after flush so stale lines would show up as bad data.
    function automatic logic [31:0] model_word(logic [31:0] line, int k, int s);
        return line ^ (32'(k) * 32'h0101_0101) ^ (32'(s) * 32'h3C00_0000) ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [127:0] model_line(logic [31:0] line, int s);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[32*k +: 32] = model_word(line, k, s);
        return l;
    endfunction

    task automatic check_eq(string tag, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
        end
    endtask

    // kind: 0 = miss, 1 = hit from IDLE, 2 = back-to-back hit in RESPOND
    task automatic fetch(input logic [31:0] a, input int kind);
        logic [31:0] line;
        logic [31:0] w;
        int          mem_cnt;
        int          cyc;
        int          exp_cyc;
        bit          fire;
        bit          done;
        bit          saw_mem;
        line    = {a[31:4], 4'h0};
        mem_cnt = 0;
        cyc     = 0;
        fire    = 0;
        done    = 0;
        saw_mem = 0;
        exp_cyc = (kind == 0) ? mem_lat + 2 : ((kind == 1) ? 1 : 0);
        @(posedge clk_i); #1;
        addr_i    = a;
        read_en_i = 1'b1;
        exp_q.push_back(model_word(line, int'(a[3:2]), salt));
        while (!done && cyc < 40) begin
            @(negedge clk_i);
            if (mem_read_en_o) begin
                if (mem_cnt == 0) check_eq("mem_addr", mem_addr_o, line);
                saw_mem = 1;
                mem_cnt++;
                fire = (mem_cnt == mem_lat);
            end
            if (read_valid_o) begin
                if (exp_q.size() == 0) begin
                    check_eq("sb_level", exp_q.size(), 1);
                end else begin
                    w = exp_q.pop_front();
                    check_eq("word", read_word_o, w);
                end
                done = 1;
            end else begin
                @(posedge clk_i); #1;
                cyc++;
                mem_read_valid_i = fire;
                if (fire) mem_read_data_i = model_line(line, salt);
                fire = 0;
            end
        end
        mem_read_valid_i = 1'b0;
        check_eq("resp_done", done, 1);
        if (!done && exp_q.size() > 0) void'(exp_q.pop_front());
        check_eq("miss_seen", saw_mem, (kind == 0));
        check_eq("latency", cyc, exp_cyc);
        if (kind == 0) exp_misses++;
        exp_hits++;
        $display("fetch addr=%h kind=%0d word=%h cycles=%0d", a, kind, read_word_o, cyc);
    endtask

    task automatic check_counts(string tag);
        @(posedge clk_i); #1;
        read_en_i = 1'b0;
        @(negedge clk_i);
        check_eq({tag, "_hits"}, hit_cnt_o, exp_hits);
        check_eq({tag, "_misses"}, miss_cnt_o, exp_misses);
        check_eq({tag, "_rvalid"}, read_valid_o, 0);
        $display("counts %s hits=%0d misses=%0d", tag, hit_cnt_o, miss_cnt_o);
    endtask

    initial begin
        rstn_i           = 1'b0;
        addr_i           = '0;
        read_en_i        = 1'b0;
        flush_i          = 1'b0;
        mem_read_valid_i = 1'b0;
        mem_read_data_i  = '0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_rvalid", read_valid_o, 0);
        check_eq("rst_word", read_word_o, 0);
        check_eq("rst_memen", mem_read_en_o, 0);
        check_eq("rst_memaddr", mem_addr_o, 0);
        check_eq("rst_hits", hit_cnt_o, 0);
        check_eq("rst_misses", miss_cnt_o, 0);
        $display("reset outputs checked");
        @(posedge clk_i); #1;
        rstn_i = 1'b1;

        // Cold miss, then the rest of the line as back-to-back hits.
        fetch(32'h0000_0104, 0);
        fetch(32'h0000_0100, 2);
        fetch(32'h0000_0108, 2);
        fetch(32'h0000_010C, 2);
        check_counts("line");

        // Three lines in one set with two ways: round-robin eviction.
        mem_lat = 3;
        fetch(32'h0000_0500, 0);
        fetch(32'h0000_0900, 0);
        fetch(32'h0000_0500, 2);
        fetch(32'h0000_0100, 0);
        fetch(32'h0000_0908, 2);
        check_counts("evict");

        // Flush while a refill is pending, with a coinciding and a late reply.
        @(posedge clk_i); #1;
        addr_i    = 32'h0000_0200;
        read_en_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_eq("flush_pre_memen", mem_read_en_o, 1);
        @(posedge clk_i); #1;
        flush_i          = 1'b1;
        mem_read_valid_i = 1'b1;
        mem_read_data_i  = model_line(32'h0000_0200, salt);
        @(posedge clk_i); #1;
        flush_i          = 1'b0;
        mem_read_valid_i = 1'b0;
        read_en_i        = 1'b0;
        @(negedge clk_i);
        check_eq("flush_memen", mem_read_en_o, 0);
        check_eq("flush_hits", hit_cnt_o, 0);
        check_eq("flush_misses", miss_cnt_o, 0);
        check_eq("flush_rvalid", read_valid_o, 0);
        $display("flush during refill applied");
        @(posedge clk_i); #1;
        mem_read_valid_i = 1'b1;
        @(posedge clk_i); #1;
        mem_read_valid_i = 1'b0;
        exp_hits   = 0;
        exp_misses = 0;
        salt++;
        fetch(32'h0000_0200, 0);
        fetch(32'h0000_0100, 0);
        check_counts("flush");

        // Request dropped mid-refill, reply arrives afterwards, then retried.
        @(posedge clk_i); #1;
        addr_i    = 32'h0000_0300;
        read_en_i = 1'b1;
        @(posedge clk_i); #1;
        @(negedge clk_i);
        check_eq("abort_memen", mem_read_en_o, 1);
        @(posedge clk_i); #1;
        read_en_i = 1'b0;
        @(posedge clk_i); #1;
        mem_read_valid_i = 1'b1;
        mem_read_data_i  = model_line(32'h0000_0300, salt);
        @(negedge clk_i);
        check_eq("abort_idle_memen", mem_read_en_o, 0);
        check_eq("abort_rvalid", read_valid_o, 0);
        @(posedge clk_i); #1;
        mem_read_valid_i = 1'b0;
        exp_misses++;
        $display("refill abandoned addr=00000300");
        fetch(32'h0000_0300, 0);
        check_counts("abort");
        fetch(32'h0000_0300, 1);

        // Asynchronous reset while responding.
        #2;
        rstn_i = 1'b0;
        #1;
        check_eq("arst_rvalid", read_valid_o, 0);
        check_eq("arst_word", read_word_o, 0);
        check_eq("arst_hits", hit_cnt_o, 0);
        check_eq("arst_misses", miss_cnt_o, 0);
        $display("async reset mid-respond");
        read_en_i = 1'b0;
        @(posedge clk_i); #1;
        rstn_i     = 1'b1;
        exp_hits   = 0;
        exp_misses = 0;
        fetch(32'h0000_0300, 0);
        fetch(32'h0000_0104, 0);
        fetch(32'h0000_0100, 2);
        check_counts("post_rst");

        check_eq("sb_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
